// File: rtl/mem_responder.sv
// Word-addressed synchronous memory answering datapath read/write requests.
// Configurable wait states before each access; completion via a four-phase Done handshake.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  Done,
  output logic                  busy
);

  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam int CNT_W       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_LOAD_I);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  is_wr_q,   is_wr_d;
  logic [DATA_WIDTH-1:0] mdatain_q, mdatain_d;
  logic                  done_q,    done_d;
  logic                  mem_we_s;

  // Next-state, request latching and output update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    is_wr_d   = is_wr_q;
    mdatain_d = mdatain_q;
    done_d    = done_q;
    mem_we_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Write || Read) begin
          addr_d  = address;
          data_d  = data_in;
          is_wr_d = Write;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_ACCESS: begin
        // Only reads touch Mdatain so it keeps the last read value across writes.
        if (is_wr_q) begin
          mem_we_s = 1'b1;
        end else begin
          mdatain_d = mem_q[addr_q];
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (!Read && !Write) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end

      default: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers, all cleared asynchronously
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      is_wr_q   <= 1'b0;
      mdatain_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      is_wr_q   <= is_wr_d;
      mdatain_q <= mdatain_d;
      done_q    <= done_d;
    end
  end

  // Storage array; deliberately not reset so clear leaves contents intact
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign Mdatain = mdatain_q;
  assign Done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a per-cycle vector table on a 2-wait-state
// instance, plus handshake sequences on 2- and 0-wait-state instances.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clear;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [8:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;
  logic [31:0] a_md, b_md;
  logic        a_done, b_done, a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut_a (
    .clock(clk), .clear(clear), .address(a_addr), .Read(a_rd), .Write(a_wr),
    .data_in(a_din), .Mdatain(a_md), .Done(a_done), .busy(a_busy)
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut_b (
    .clock(clk), .clear(clear), .address(b_addr), .Read(b_rd), .Write(b_wr),
    .data_in(b_din), .Mdatain(b_md), .Done(b_done), .busy(b_busy)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] din;
    logic        exp_done;
    logic        exp_busy;
    logic [31:0] exp_md;
  } vec_t;

  vec_t vecs[31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete request on instance A (sel=0) or B (sel=1), including release.
  task automatic req(input bit sel, input bit rd, input bit wr, input logic [8:0] addr,
                     input logic [31:0] din, input int exp_lat, input bit chk_md,
                     input logic [31:0] exp_md);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    if (sel) begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_din = din;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_din = din;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if ((sel ? b_done : a_done) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat, exp_lat);
    if (chk_md) check("rdata", sel ? b_md : a_md, exp_md);
    if (sel) begin
      b_rd = 1'b0; b_wr = 1'b0;
    end else begin
      a_rd = 1'b0; a_wr = 1'b0;
    end
    @(posedge clk); #1;
    check("release_done", {31'd0, sel ? b_done : a_done}, 32'd0);
    check("release_busy", {31'd0, sel ? b_busy : a_busy}, 32'd0);
  endtask

  initial begin
    // write, with mid-WAIT input changes that must be ignored
    vecs[0]  = '{1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 9'h006, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 9'h006, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 9'h006, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 32'h0};
    // read back
    vecs[5]  = '{1'b1, 1'b0, 9'h005, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 9'h005, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 9'h005, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 9'h005, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b0, 9'h005, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    // simultaneous strobes: write wins, Mdatain untouched
    vecs[10] = '{1'b1, 1'b1, 9'h01F, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 1'b1, 9'h01F, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 1'b1, 9'h01F, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[13] = '{1'b1, 1'b1, 9'h01F, 32'h12345678, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[14] = '{1'b0, 1'b0, 9'h01F, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[15] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[16] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[17] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[18] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b1, 1'b1, 32'h12345678};
    // held handshake: Read stays high 5 more cycles
    vecs[19] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b1, 1'b1, 32'h12345678};
    vecs[20] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b1, 1'b1, 32'h12345678};
    vecs[21] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b1, 1'b1, 32'h12345678};
    vecs[22] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b1, 1'b1, 32'h12345678};
    vecs[23] = '{1'b1, 1'b0, 9'h01F, 32'h0, 1'b1, 1'b1, 32'h12345678};
    vecs[24] = '{1'b0, 1'b0, 9'h01F, 32'h0, 1'b0, 1'b0, 32'h12345678};
    // strobe released during WAIT: access still completes
    vecs[25] = '{1'b1, 1'b0, 9'h005, 32'h0, 1'b0, 1'b1, 32'h12345678};
    vecs[26] = '{1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b1, 32'h12345678};
    vecs[27] = '{1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b1, 32'h12345678};
    vecs[28] = '{1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[29] = '{1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[30] = '{1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};

    clear = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_addr = 9'h000; a_din = 32'h0;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 9'h000; b_din = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_md", a_md, 32'h0);
    check("reset_done", {31'd0, a_done}, 32'd0);
    check("reset_busy", {31'd0, a_busy}, 32'd0);
    clear = 1'b0;

    for (int i = 0; i < 31; i++) begin
      a_rd = vecs[i].rd; a_wr = vecs[i].wr; a_addr = vecs[i].addr; a_din = vecs[i].din;
      @(posedge clk); #1;
      check($sformatf("vec%0d_done", i), {31'd0, a_done}, {31'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_busy", i), {31'd0, a_busy}, {31'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d_md", i), a_md, vecs[i].exp_md);
    end

    // reset mid-write: the interrupted write must not commit
    req(1'b0, 1'b0, 1'b1, 9'h000, 32'h11111111, 4, 1'b0, 32'h0);
    a_wr = 1'b1; a_addr = 9'h000; a_din = 32'hAAAA5555;
    @(posedge clk); #1;
    check("midwr_busy", {31'd0, a_busy}, 32'd1);
    #2;
    clear = 1'b1;
    #1;
    check("async_clr_md", a_md, 32'h0);
    check("async_clr_done", {31'd0, a_done}, 32'd0);
    check("async_clr_busy", {31'd0, a_busy}, 32'd0);
    a_wr = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    req(1'b0, 1'b1, 1'b0, 9'h000, 32'h0, 4, 1'b1, 32'h11111111);
    req(1'b0, 1'b1, 1'b0, 9'h005, 32'h0, 4, 1'b1, 32'hDEADBEEF);

    // zero wait states, top address
    req(1'b1, 1'b0, 1'b1, 9'h1FF, 32'h5A5A0FF0, 2, 1'b0, 32'h0);
    req(1'b1, 1'b0, 1'b1, 9'h000, 32'h01234567, 2, 1'b0, 32'h0);
    req(1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0, 2, 1'b1, 32'h5A5A0FF0);
    req(1'b1, 1'b1, 1'b0, 9'h000, 32'h0, 2, 1'b1, 32'h01234567);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
